// File: rtl/debug_unit_if.sv
// Bundle of the host byte link, imem write port, CPU control and register-bank read port.
// The master side is the debug unit; the slave side is the host/CPU environment.
interface debug_unit_if #(
  parameter int IMEM_ADDR_W = 8
);
  logic [7:0]             i_rx_data;
  logic                   i_rx_valid;
  logic                   o_rx_ready;
  logic [7:0]             o_tx_data;
  logic                   o_tx_valid;
  logic                   i_tx_ready;
  logic                   o_imem_we;
  logic [IMEM_ADDR_W-1:0] o_imem_addr;
  logic [31:0]            o_imem_wdata;
  logic                   o_cpu_reset;
  logic                   i_halt;
  logic [4:0]             o_reg_addr;
  logic [31:0]            i_reg_data;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_ready, i_halt, i_reg_data,
    output o_rx_ready, o_tx_data, o_tx_valid, o_imem_we, o_imem_addr,
           o_imem_wdata, o_cpu_reset, o_reg_addr
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_ready, i_halt, i_reg_data,
    input  o_rx_ready, o_tx_data, o_tx_valid, o_imem_we, o_imem_addr,
           o_imem_wdata, o_cpu_reset, o_reg_addr
  );
endinterface

// File: rtl/debug_unit.sv
// Byte-stream program loader and register dumper for the mips core: loads imem while the
// CPU is held in reset, runs it until halt, then streams all registers back MSB first.
module debug_unit #(
  parameter int IMEM_ADDR_W = 8,
  parameter int NUM_REGS    = 32
) (
  input logic         clk,
  input logic         reset,
  debug_unit_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CNT,
    LOAD_BYTE,
    RUN,
    DUMP_LATCH,
    DUMP_SEND
  } state_t;

  localparam logic [7:0]             CMD_LOAD = 8'h4C;
  localparam logic [7:0]             CMD_RUN  = 8'h52;
  localparam logic [4:0]             LAST_REG = 5'(NUM_REGS - 1);
  localparam logic [IMEM_ADDR_W-1:0] ADDR_ONE = IMEM_ADDR_W'(1);

  state_t                 state;
  logic [7:0]             word_cnt;
  logic [1:0]             byte_idx;
  logic [23:0]            partial;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [31:0]            imem_wdata;
  logic                   imem_we;
  logic [31:0]            shift;
  logic [4:0]             reg_idx;
  logic                   cpu_reset;
  logic                   rx_ready;
  logic                   tx_valid;
  logic                   rx_fire;
  logic                   tx_fire;

  always_comb begin
    rx_ready = (state == IDLE) || (state == LOAD_CNT) || (state == LOAD_BYTE);
    tx_valid = (state == DUMP_SEND);
    rx_fire  = bus.i_rx_valid && rx_ready;
    tx_fire  = tx_valid && bus.i_tx_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      word_cnt   <= '0;
      byte_idx   <= '0;
      partial    <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      imem_we    <= 1'b0;
      shift      <= '0;
      reg_idx    <= '0;
      cpu_reset  <= 1'b1;
    end else begin
      // The write strobe lasts one cycle; the address advances only after it has been seen.
      imem_we <= 1'b0;
      if (imem_we) imem_addr <= imem_addr + ADDR_ONE;

      case (state)
        IDLE: begin
          if (rx_fire) begin
            if (bus.i_rx_data == CMD_LOAD) begin
              state <= LOAD_CNT;
            end else if (bus.i_rx_data == CMD_RUN) begin
              state     <= RUN;
              cpu_reset <= 1'b0;
            end
          end
        end

        LOAD_CNT: begin
          if (rx_fire) begin
            word_cnt  <= bus.i_rx_data;
            imem_addr <= '0;
            byte_idx  <= '0;
            state     <= (bus.i_rx_data == 8'd0) ? IDLE : LOAD_BYTE;
          end
        end

        LOAD_BYTE: begin
          if (rx_fire) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_wdata <= {partial, bus.i_rx_data};
              imem_we    <= 1'b1;
              word_cnt   <= word_cnt - 8'd1;
              if (word_cnt == 8'd1) state <= IDLE;
            end else begin
              partial <= {partial[15:0], bus.i_rx_data};
            end
          end
        end

        RUN: begin
          if (bus.i_halt) begin
            reg_idx <= '0;
            state   <= DUMP_LATCH;
          end
        end

        DUMP_LATCH: begin
          shift    <= bus.i_reg_data;
          byte_idx <= '0;
          state    <= DUMP_SEND;
        end

        DUMP_SEND: begin
          if (tx_fire) begin
            shift    <= {shift[23:0], 8'h00};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              if (reg_idx == LAST_REG) begin
                state     <= IDLE;
                cpu_reset <= 1'b1;
              end else begin
                reg_idx <= reg_idx + 5'd1;
                state   <= DUMP_LATCH;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_rx_ready   = rx_ready;
  assign bus.o_tx_valid   = tx_valid;
  assign bus.o_tx_data    = shift[31:24];
  assign bus.o_imem_we    = imem_we;
  assign bus.o_imem_addr  = imem_addr;
  assign bus.o_imem_wdata = imem_wdata;
  assign bus.o_cpu_reset  = cpu_reset;
  assign bus.o_reg_addr   = reg_idx;

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit: table-driven command bytes with a scoreboard of
// expected imem writes and dump bytes, plus stall, run and mid-load reset sequences.
module tb_debug_unit;

  logic clk = 1'b0;
  logic reset;
  logic toggle_mode;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   run_cycles = 0;

  debug_unit_if #(.IMEM_ADDR_W(8)) bus ();

  debug_unit #(.IMEM_ADDR_W(8), .NUM_REGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register bank model: register n reads as 0x100 + n.
  assign bus.i_reg_data = 32'h100 + {27'd0, bus.o_reg_addr};

  // CPU model (halts 40 cycles after leaving reset) and tx-ready pattern.
  always @(posedge clk) begin
    #1;
    if (bus.o_cpu_reset) begin
      run_cycles = 0;
      bus.i_halt = 1'b0;
    end else if (run_cycles >= 40) begin
      bus.i_halt = 1'b1;
    end else begin
      run_cycles++;
    end
    if (toggle_mode) bus.i_tx_ready = ~bus.i_tx_ready;
    else             bus.i_tx_ready = 1'b1;
  end

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  data;
    logic        exp_cpu_reset;
    logic        exp_rx_ready;
    logic        push_wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        push_dump;
  } vec_t;

  wr_t        wq[$];
  logic [7:0] txq[$];
  vec_t       vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic cr, input logic rr,
                              input logic pw, input logic [7:0] a, input logic [31:0] w,
                              input logic pd);
    vec_t v;
    v.data = d; v.exp_cpu_reset = cr; v.exp_rx_ready = rr;
    v.push_wr = pw; v.addr = a; v.wdata = w; v.push_dump = pd;
    return v;
  endfunction

  task automatic push_dump();
    logic [31:0] w;
    for (int r = 0; r < 32; r++) begin
      w = 32'h100 + 32'(r);
      for (int b = 3; b >= 0; b--) txq.push_back(w[8*b +: 8]);
    end
  endtask

  // Monitor: scoreboard pops, tx hold-while-stalled, and cpu_reset return after the last byte.
  logic       prev_stall  = 1'b0;
  logic [7:0] prev_data   = 8'h00;
  logic       expect_rise = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall  = 1'b0;
      expect_rise = 1'b0;
    end else begin
      if (prev_stall) begin
        check("tx_hold_valid", 32'(bus.o_tx_valid), 32'd1);
        check("tx_hold_data", 32'(bus.o_tx_data), 32'(prev_data));
      end
      if (expect_rise) begin
        check("cpu_reset_rise", 32'(bus.o_cpu_reset), 32'd1);
        expect_rise = 1'b0;
      end
      if (bus.o_imem_we) begin
        if (wq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL imem_unexpected_write: addr %h data %h, no write expected",
                   bus.o_imem_addr, bus.o_imem_wdata);
        end else begin
          wr_t e;
          e = wq.pop_front();
          check("imem_addr", 32'(bus.o_imem_addr), 32'(e.addr));
          check("imem_wdata", bus.o_imem_wdata, e.data);
        end
      end
      if (bus.o_tx_valid && bus.i_tx_ready) begin
        if (txq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tx_unexpected_byte: got %h, no byte expected", bus.o_tx_data);
        end else begin
          check("tx_byte", 32'(bus.o_tx_data), 32'(txq.pop_front()));
          check("cpu_reset_during_dump", 32'(bus.o_cpu_reset), 32'd0);
          if (txq.size() == 0) expect_rise = 1'b1;
        end
      end
      prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
      prev_data  = bus.o_tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(negedge clk);
    while (!bus.o_rx_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.o_rx_ready) begin
      n_checks++; n_fail++;
      $display("FAIL rx_accept: ready 0 after 100 cycles, expected 1");
    end else begin
      @(posedge clk);
    end
    #1 bus.i_rx_valid = 1'b0;
  endtask

  task automatic wait_dump();
    int n = 0;
    while ((txq.size() != 0 || expect_rise) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("dump_complete_remaining", 32'(txq.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_reset"}, 32'(bus.o_cpu_reset), 32'd1);
    check({tag, "_imem_we"}, 32'(bus.o_imem_we), 32'd0);
    check({tag, "_imem_addr"}, 32'(bus.o_imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, bus.o_imem_wdata, 32'd0);
    check({tag, "_tx_valid"}, 32'(bus.o_tx_valid), 32'd0);
    check({tag, "_tx_data"}, 32'(bus.o_tx_data), 32'd0);
    check({tag, "_reg_addr"}, 32'(bus.o_reg_addr), 32'd0);
    check({tag, "_rx_ready"}, 32'(bus.o_rx_ready), 32'd1);
  endtask

  initial begin
    vecs[0]  = mk(8'h4C, 1'b1, 1'b1, 1'b0, 8'd0, 32'h0, 1'b0);
    vecs[1]  = mk(8'h02, 1'b1, 1'b1, 1'b0, 8'd0, 32'h0, 1'b0);
    vecs[2]  = mk(8'h20, 1'b1, 1'b1, 1'b0, 8'd0, 32'h0, 1'b0);
    vecs[3]  = mk(8'h01, 1'b1, 1'b1, 1'b0, 8'd0, 32'h0, 1'b0);
    vecs[4]  = mk(8'h00, 1'b1, 1'b1, 1'b0, 8'd0, 32'h0, 1'b0);
    vecs[5]  = mk(8'h05, 1'b1, 1'b1, 1'b1, 8'd0, 32'h20010005, 1'b0);
    vecs[6]  = mk(8'h20, 1'b1, 1'b1, 1'b0, 8'd0, 32'h0, 1'b0);
    vecs[7]  = mk(8'h02, 1'b1, 1'b1, 1'b0, 8'd0, 32'h0, 1'b0);
    vecs[8]  = mk(8'h00, 1'b1, 1'b1, 1'b0, 8'd0, 32'h0, 1'b0);
    vecs[9]  = mk(8'h64, 1'b1, 1'b1, 1'b1, 8'd1, 32'h20020064, 1'b0);
    vecs[10] = mk(8'h4C, 1'b1, 1'b1, 1'b0, 8'd0, 32'h0, 1'b0);
    vecs[11] = mk(8'h00, 1'b1, 1'b1, 1'b0, 8'd0, 32'h0, 1'b0);
    vecs[12] = mk(8'h99, 1'b1, 1'b1, 1'b0, 8'd0, 32'h0, 1'b0);
    vecs[13] = mk(8'h52, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0, 1'b1);

    reset          = 1'b1;
    toggle_mode    = 1'b0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Load two words, L/0/ignored byte, then run and dump with tx always ready.
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].push_wr) wq.push_back('{addr: vecs[i].addr, data: vecs[i].wdata});
      if (vecs[i].push_dump) push_dump();
      send_byte(vecs[i].data);
      check($sformatf("vec%0d_cpu_reset", i), 32'(bus.o_cpu_reset), 32'(vecs[i].exp_cpu_reset));
      check($sformatf("vec%0d_rx_ready", i), 32'(bus.o_rx_ready), 32'(vecs[i].exp_rx_ready));
    end
    check("run_tx_valid", 32'(bus.o_tx_valid), 32'd0);
    check("writes_pending_after_load", 32'(wq.size()), 32'd0);
    wait_dump();

    // Second dump with tx-ready toggling every cycle.
    toggle_mode = 1'b1;
    push_dump();
    send_byte(8'h52);
    check("run2_cpu_reset", 32'(bus.o_cpu_reset), 32'd0);
    wait_dump();
    toggle_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset two bytes into the second word of a load.
    wq.push_back('{addr: 8'd0, data: 32'h11223344});
    send_byte(8'h4C); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    reset = 1'b1;
    #1;
    check_reset_values("async");
    @(posedge clk);
    #1 reset = 1'b0;

    wq.push_back('{addr: 8'd0, data: 32'hAABBCCDD});
    send_byte(8'h4C); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    repeat (3) @(posedge clk);
    #1;
    check("final_writes_pending", 32'(wq.size()), 32'd0);
    check("final_tx_pending", 32'(txq.size()), 32'd0);
    check("final_cpu_reset", 32'(bus.o_cpu_reset), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
